// File: rtl/big_core_portb_arb_pkg.sv
// Shared types for the port-B arbiter: tile transaction format, arbiter state/source
// enums and the response builder used when a fabric read returns.
package big_core_portb_arb_pkg;

    typedef logic [7:0] t_tile_id;

    typedef enum logic [1:0] {
        NOP    = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RD_RSP = 2'd3
    } t_tile_opcode;

    localparam t_tile_id NULL_CARDINAL = 8'hFF;

    typedef struct packed {
        logic [31:0]  address;
        t_tile_opcode opcode;
        logic [31:0]  data;
        t_tile_id     requestor_id;
        t_tile_id     next_tile_fifo_arb_id;
    } t_tile_trans;

    typedef enum logic {PORTB_RR = 1'b0, PORTB_LDR_LOCKED = 1'b1} t_portb_arb_state;
    typedef enum logic {SRC_FAB = 1'b0, SRC_LDR = 1'b1} t_portb_src;

    localparam int PORTB_RD_LATENCY = 1;

    // tag carries {requestor_id[7:0], address[23:0]} captured at issue time
    function automatic t_tile_trans mkRdRsp(input logic [31:0] tag,
                                            input logic [31:0] rdData,
                                            input t_tile_id    tileId);
        t_tile_trans r;
        r.address               = tag;
        r.opcode                = RD_RSP;
        r.data                  = rdData;
        r.requestor_id          = tileId;
        r.next_tile_fifo_arb_id = NULL_CARDINAL;
        return r;
    endfunction

endpackage

// File: rtl/big_core_portb_arb_if.sv
// Fabric, loader and memory port-B signal bundle for big_core_portb_arb.
// slave = arbiter side, master = fabric/loader/memory side.
interface big_core_portb_arb_if;
    import big_core_portb_arb_pkg::*;

    logic        InFabricValid;
    t_tile_trans InFabricReq;
    logic        InFabricReady;

    logic        OutFabricValid;
    t_tile_trans OutFabricRsp;
    logic        OutFabricReady;

    logic        LdrReqValid;
    logic        LdrReqWr;
    logic [31:0] LdrReqAddr;
    logic [31:0] LdrReqData;
    logic        LdrLock;
    logic        LdrReqReady;
    logic        LdrRspValid;
    logic [31:0] LdrRspData;

    logic [31:0] PortBAddr;
    logic [31:0] PortBData;
    logic        PortBWrEn;
    logic        PortBRdEn;
    logic [31:0] PortBRdData;

    modport slave (
        input  InFabricValid, InFabricReq, OutFabricReady,
        input  LdrReqValid, LdrReqWr, LdrReqAddr, LdrReqData, LdrLock,
        input  PortBRdData,
        output InFabricReady, OutFabricValid, OutFabricRsp,
        output LdrReqReady, LdrRspValid, LdrRspData,
        output PortBAddr, PortBData, PortBWrEn, PortBRdEn
    );

    modport master (
        output InFabricValid, InFabricReq, OutFabricReady,
        output LdrReqValid, LdrReqWr, LdrReqAddr, LdrReqData, LdrLock,
        output PortBRdData,
        input  InFabricReady, OutFabricValid, OutFabricRsp,
        input  LdrReqReady, LdrRspValid, LdrRspData,
        input  PortBAddr, PortBData, PortBWrEn, PortBRdEn
    );

endinterface

// File: rtl/big_core_portb_arb_rsp_fifo.sv
// Synchronous FIFO of tile transactions with an occupancy count; pointers carry
// one extra wrap bit so full and empty are distinguishable.
module big_core_portb_rsp_fifo
    import big_core_portb_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        push,
    input  t_tile_trans pushData,
    input  logic        pop,
    output t_tile_trans popData,
    output logic        empty,
    output logic [AW:0] count
);

    logic [AW:0] wrPtr, rdPtr;
    logic        full, doPush, doPop;
    t_tile_trans mem [DEPTH];

    assign count   = wrPtr - rdPtr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end

    // Credit accounting upstream must make this unreachable.
    pushWhenFull: assert property (@(posedge Clk) disable iff (!Rst) !(push && full));

endmodule

// File: rtl/big_core_portb_arb.sv
// Port-B arbiter for I_MEM/D_MEM/CR_MEM: shares the port between fabric and loader,
// tracks 1-cycle read latency, buffers fabric read responses behind read credits.
// Optional: define BIG_CORE_PORTB_ARB_STATS_EN for grant/stall counters and stat ports.
module big_core_portb_arb
    import big_core_portb_arb_pkg::*;
#(
    parameter int RSP_FIFO_DEPTH = 4,
    parameter int LOCK_MAX       = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  t_tile_id    local_tile_id,
`ifdef BIG_CORE_PORTB_ARB_STATS_EN
    output logic [31:0] StatFabGrants,
    output logic [31:0] StatLdrGrants,
    output logic [31:0] StatCreditStalls,
`endif
    big_core_portb_arb_if.slave bus
);

    localparam int CW  = $clog2(RSP_FIFO_DEPTH) + 1;
    localparam int LCW = $clog2(LOCK_MAX + 1);
    localparam int PL  = PORTB_RD_LATENCY;

    t_portb_arb_state state, stateNxt;
    t_portb_src       rrPtr, rrPtrNxt;
    logic [LCW-1:0]   lockCnt, lockCntNxt;

    logic fabIsRd, fabIsWr, fabCredit, fabElig, ldrElig;
    logic fabGnt, ldrGnt, fabRdIssue, ldrRdIssue;

    logic [PL-1:0]       fabRdPipe, ldrRdPipe;
    logic [PL-1:0][31:0] tagPipe;
    logic [31:0]         fabTag;

    logic          fifoEmpty;
    logic [CW-1:0] fifoCount;
    t_tile_trans   fifoRsp, pushRsp;
    logic          unusedFabBits;

    assign fabIsRd   = (bus.InFabricReq.opcode == RD);
    assign fabIsWr   = (bus.InFabricReq.opcode == WR);
    assign fabCredit = (int'(fifoCount) + $countones(fabRdPipe)) < RSP_FIFO_DEPTH;
    assign fabElig   = bus.InFabricValid && (!fabIsRd || fabCredit);
    assign ldrElig   = bus.LdrReqValid;
    assign fabTag    = {bus.InFabricReq.requestor_id, bus.InFabricReq.address[23:0]};
    assign unusedFabBits = ^{bus.InFabricReq.next_tile_fifo_arb_id};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= PORTB_RR;
            rrPtr     <= SRC_FAB;
            lockCnt   <= '0;
            fabRdPipe <= '0;
            ldrRdPipe <= '0;
            tagPipe   <= '0;
        end else begin
            state     <= stateNxt;
            rrPtr     <= rrPtrNxt;
            lockCnt   <= lockCntNxt;
            fabRdPipe <= (fabRdPipe << 1) | PL'(fabRdIssue);
            ldrRdPipe <= (ldrRdPipe << 1) | PL'(ldrRdIssue);
            for (int i = PL - 1; i > 0; i--) tagPipe[i] <= tagPipe[i-1];
            tagPipe[0] <= fabTag;
        end
    end

    always_comb begin
        fabGnt     = 1'b0;
        ldrGnt     = 1'b0;
        stateNxt   = state;
        rrPtrNxt   = rrPtr;
        lockCntNxt = lockCnt;
        case (state)
            PORTB_RR: begin
                if (fabElig && (!ldrElig || rrPtr == SRC_FAB)) fabGnt = 1'b1;
                else if (ldrElig)                               ldrGnt = 1'b1;
                if (fabGnt) rrPtrNxt = SRC_LDR;
                if (ldrGnt) begin
                    rrPtrNxt = SRC_FAB;
                    if (bus.LdrLock) begin
                        stateNxt   = PORTB_LDR_LOCKED;
                        lockCntNxt = LCW'(1);
                    end
                end
            end
            PORTB_LDR_LOCKED: begin
                // A saturated lock with fabric waiting yields the port without a loader grant.
                if (lockCnt == LCW'(LOCK_MAX) && bus.InFabricValid) begin
                    stateNxt   = PORTB_RR;
                    rrPtrNxt   = SRC_FAB;
                    lockCntNxt = '0;
                end else begin
                    ldrGnt = ldrElig;
                    if (ldrGnt && lockCnt != LCW'(LOCK_MAX)) lockCntNxt = lockCnt + 1'b1;
                    if (!bus.LdrLock || (lockCntNxt == LCW'(LOCK_MAX) && bus.InFabricValid)) begin
                        stateNxt   = PORTB_RR;
                        rrPtrNxt   = SRC_FAB;
                        lockCntNxt = '0;
                    end
                end
            end
            default: stateNxt = PORTB_RR;
        endcase
    end

    assign fabRdIssue = fabGnt && fabIsRd;
    assign ldrRdIssue = ldrGnt && !bus.LdrReqWr;

    always_comb begin
        bus.InFabricReady = fabGnt;
        bus.LdrReqReady   = ldrGnt;
        bus.PortBAddr     = '0;
        bus.PortBData     = '0;
        bus.PortBWrEn     = 1'b0;
        bus.PortBRdEn     = 1'b0;
        if (fabGnt && (fabIsRd || fabIsWr)) begin
            bus.PortBAddr = bus.InFabricReq.address;
            bus.PortBData = fabIsWr ? bus.InFabricReq.data : 32'h0;
            bus.PortBWrEn = fabIsWr;
            bus.PortBRdEn = fabIsRd;
        end else if (ldrGnt) begin
            bus.PortBAddr = bus.LdrReqAddr;
            bus.PortBData = bus.LdrReqWr ? bus.LdrReqData : 32'h0;
            bus.PortBWrEn = bus.LdrReqWr;
            bus.PortBRdEn = !bus.LdrReqWr;
        end
    end

    assign bus.LdrRspValid = ldrRdPipe[PL-1];
    assign bus.LdrRspData  = ldrRdPipe[PL-1] ? bus.PortBRdData : 32'h0;
    assign pushRsp         = mkRdRsp(tagPipe[PL-1], bus.PortBRdData, local_tile_id);

    big_core_portb_rsp_fifo #(.DEPTH(RSP_FIFO_DEPTH)) rspFifo (
        .Clk      (Clk),
        .Rst      (Rst),
        .push     (fabRdPipe[PL-1]),
        .pushData (pushRsp),
        .pop      (bus.OutFabricValid && bus.OutFabricReady),
        .popData  (fifoRsp),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    assign bus.OutFabricValid = !fifoEmpty;
    assign bus.OutFabricRsp   = fifoEmpty ? '0 : fifoRsp;

`ifdef BIG_CORE_PORTB_ARB_STATS_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            StatFabGrants    <= '0;
            StatLdrGrants    <= '0;
            StatCreditStalls <= '0;
        end else begin
            if (fabGnt && ~&StatFabGrants) StatFabGrants <= StatFabGrants + 32'd1;
            if (ldrGnt && ~&StatLdrGrants) StatLdrGrants <= StatLdrGrants + 32'd1;
            if (bus.InFabricValid && fabIsRd && !fabCredit && ~&StatCreditStalls)
                StatCreditStalls <= StatCreditStalls + 32'd1;
        end
    end
`else
    // Statistics build option off: no counters and no stat ports.
`endif

endmodule
